// File: rtl/frame_slicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_slicer                                                               |
// | Buffers WORDS x WORD_W frames in a small FIFO and emits each one as a      |
// | stream of SLICE_W-bit slices, LSB first, zero padded at the top.           |
// | Optional feature macro: FRAME_SLICER_PARITY_EN (out_par / in_par_err_inj). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module frame_slicer #(
    parameter int WORD_W  = 32,
    parameter int WORDS   = 3,
    parameter int SLICE_W = 9,
    parameter int DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_frame,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLICE_W-1:0]      out_data,
    output logic [3:0]              out_idx,
    output logic                    out_last,
    output logic [15:0]             frames_done
`ifdef FRAME_SLICER_PARITY_EN
    ,
    output logic                    out_par,
    input  logic                    in_par_err_inj
`endif
);

    localparam int c_frame_w = WORDS * WORD_W;
    localparam int c_nsl     = (c_frame_w + SLICE_W - 1) / SLICE_W;
    localparam int c_shift_w = c_nsl * SLICE_W;
    localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [3:0]         c_last_idx = 4'(c_nsl - 1);

    if (c_nsl > 16) begin : g_nsl_check
        $error("frame_slicer: slice count exceeds the 4-bit out_idx range");
    end

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_frame_w-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_clear;
    logic                   w_done_inc;
    logic [c_shift_w-1:0]   w_head_ext;
    logic [c_shift_w-1:0]   w_shift_next;
    logic [c_shift_w-1:0]   r_shift;
    logic [3:0]             r_idx;
    logic                   r_last;
    logic [15:0]            r_frames_done;

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even when the FSM pops in the same cycle.
    assign in_ready     = !rst && (r_count < c_depth);
    assign w_push       = in_valid && in_ready;
    assign w_head_ext   = c_shift_w'(r_mem[r_rd_ptr]);
    assign w_shift_next = r_shift >> SLICE_W;

    assign out_valid   = (r_state == S_STREAM);
    assign out_data    = r_shift[SLICE_W-1:0];
    assign out_idx     = r_idx;
    assign out_last    = r_last;
    assign frames_done = r_frames_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_done_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (r_last) begin
                        w_done_inc = 1'b1;
                        // Chain straight into the next queued frame: no bubble.
                        if (r_count != '0) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_clear      = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_shift <= w_head_ext;
            r_idx   <= '0;
            r_last  <= (c_nsl == 1);
        end else if (w_shift) begin
            r_shift <= w_shift_next;
            r_idx   <= r_idx + 4'd1;
            r_last  <= ((r_idx + 4'd1) == c_last_idx);
        end else if (w_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_done <= '0;
        end else if (w_done_inc) begin
            r_frames_done <= r_frames_done + 16'd1;
        end
    end

`ifdef FRAME_SLICER_PARITY_EN
    logic [DEPTH-1:0] r_inj;
    logic             r_par;

    assign out_par = r_par;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inj[r_wr_ptr] <= in_par_err_inj;
        end
    end

    // Parity is registered alongside the slice it covers; the injected error
    // only touches slice 0 of the flagged frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= (^w_head_ext[SLICE_W-1:0]) ^ r_inj[r_rd_ptr];
        end else if (w_shift) begin
            r_par <= ^w_shift_next[SLICE_W-1:0];
        end else if (w_clear) begin
            r_par <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_slicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_slicer                                                            |
// | Directed self-checking bench for frame_slicer.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_frame_slicer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_frame = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [15:0] frames_done;
`ifdef FRAME_SLICER_PARITY_EN
    logic        out_par;
    logic        in_par_err_inj = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0]  obs [11];
    logic [10:0] obs_par;

    always #5 clk = ~clk;

    frame_slicer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_frame    (in_frame),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .frames_done (frames_done)
`ifdef FRAME_SLICER_PARITY_EN
        ,
        .out_par        (out_par),
        .in_par_err_inj (in_par_err_inj)
`endif
    );

    function automatic logic [95:0] mk(input logic [31:0] w4, input logic [31:0] w3,
                                       input logic [31:0] w2);
        return {w4, w3, w2};
    endfunction

    function automatic logic [8:0] slice_of(input logic [95:0] f, input int k);
        logic [98:0] e;
        e = {3'b000, f};
        return e[k*9 +: 9];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait: out_valid actual=%b required=1", nm, out_valid);
        end
    endtask

    task automatic send_frame(input logic [95:0] f);
        int t;
        t = 0;
        in_frame = f;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send accept: in_ready actual=%b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Expects slice 0 to be presented now and out_ready high; every later
    // slice must follow on the very next cycle.
    task automatic stream_frame(input logic [95:0] f, input bit inv0, input string nm);
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== slice_of(f, k) ||
                out_last !== (k == 10)) begin
                n_fail++;
                $display("FAIL %s slice %0d: valid/idx/data/last actual=%b/%0d/%h/%b required=1/%0d/%h/%b",
                         nm, k, out_valid, out_idx, out_data, out_last, k, slice_of(f, k), (k == 10));
            end
            obs[k] = out_data;
`ifdef FRAME_SLICER_PARITY_EN
            obs_par[k] = out_par;
            n_checks++;
            if (out_par !== ((^slice_of(f, k)) ^ (inv0 && k == 0))) begin
                n_fail++;
                $display("FAIL %s parity %0d: actual=%b required=%b", nm, k, out_par,
                         (^slice_of(f, k)) ^ (inv0 && k == 0));
            end
`else
            obs_par[k] = inv0;
`endif
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 9'h000 || out_idx !== 4'd0 ||
            out_last !== 1'b0 || frames_done !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset state: rdy/vld/data/idx/last/done actual=%b/%b/%h/%0d/%b/%h required=0/0/000/0/0/0000",
                     in_ready, out_valid, out_data, out_idx, out_last, frames_done);
        end
`ifdef FRAME_SLICER_PARITY_EN
        n_checks++;
        if (out_par !== 1'b0) begin
            n_fail++;
            $display("FAIL reset parity: actual=%b required=0", out_par);
        end
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset release in_ready: actual=%b required=1", in_ready);
        end
    endtask

    task automatic test_pattern();
        logic [8:0] e;
        out_ready = 1'b1;
        send_frame(mk(32'h5, 32'h0, 32'h4));
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency early: out_valid actual=%b required=0", out_valid);
        end
        tick();
        stream_frame(mk(32'h5, 32'h0, 32'h4), 1'b0, "pattern");
        for (int k = 0; k < 11; k++) begin
            e = (k == 0) ? 9'h004 : (k == 7) ? 9'h00A : 9'h000;
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL pattern hand slice %0d: actual=%h required=%h", k, obs[k], e);
            end
        end
        n_checks++;
        if (frames_done !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern done: frames_done/out_valid actual=%0d/%b required=1/0",
                     frames_done, out_valid);
        end
    endtask

    task automatic test_all_ones();
        logic [8:0] e;
        out_ready = 1'b1;
        send_frame({96{1'b1}});
        wait_valid("all_ones");
        stream_frame({96{1'b1}}, 1'b0, "all_ones");
        for (int k = 0; k < 11; k++) begin
            e = (k < 10) ? 9'h1FF : 9'h03F;
            n_checks++;
            if (obs[k] !== e) begin
                n_fail++;
                $display("FAIL all_ones hand slice %0d: actual=%h required=%h", k, obs[k], e);
            end
`ifdef FRAME_SLICER_PARITY_EN
            n_checks++;
            if (obs_par[k] !== (k < 10)) begin
                n_fail++;
                $display("FAIL all_ones hand parity %0d: actual=%b required=%b", k, obs_par[k], (k < 10));
            end
`endif
        end
        n_checks++;
        if (frames_done !== 16'd2) begin
            n_fail++;
            $display("FAIL all_ones done: actual=%0d required=2", frames_done);
        end
    endtask

    task automatic test_backpressure();
        logic [95:0] f;
        f = mk(32'hDEADBEEF, 32'h12345678, 32'hA5A5F00F);
        out_ready = 1'b1;
        send_frame(f);
        wait_valid("backpressure");
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== slice_of(f, k)) begin
                n_fail++;
                $display("FAIL backpressure slice %0d: valid/idx/data actual=%b/%0d/%h required=1/%0d/%h",
                         k, out_valid, out_idx, out_data, k, slice_of(f, k));
            end
            if (k == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    n_checks++;
                    if (out_valid !== 1'b1 || out_idx !== 4'd3 || out_data !== slice_of(f, 3) ||
                        out_last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL backpressure hold %0d: valid/idx/data/last actual=%b/%0d/%h/%b required=1/3/%h/0",
                                 s, out_valid, out_idx, out_data, out_last, slice_of(f, 3));
                    end
                end
                out_ready = 1'b1;
            end
            tick();
        end
        n_checks++;
        if (frames_done !== 16'd3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure done: frames_done/out_valid actual=%0d/%b required=3/0",
                     frames_done, out_valid);
        end
    endtask

    task automatic test_fill();
        logic [95:0] fr [4];
        int acc;
        fr[0] = mk(32'h11111111, 32'h22222222, 32'h33333333);
        fr[1] = mk(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF);
        fr[2] = mk(32'h80000001, 32'h7FFFFFFE, 32'h13579BDF);
        fr[3] = mk(32'hCAFEF00D, 32'h0BADC0DE, 32'h600DCAFE);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_frame = fr[i];
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill accept %0d: in_ready actual=%b required=1", i, in_ready);
            end
            tick();
        end
        in_frame = fr[3];
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 4'd0) begin
                n_fail++;
                $display("FAIL fill full %0d: in_ready/out_valid/idx actual=%b/%b/%0d required=0/1/0",
                         i, in_ready, out_valid, out_idx);
            end
            tick();
        end
        out_ready = 1'b1;
        acc = -1;
        for (int c = 0; c < 33; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(c % 11) || out_data !== slice_of(fr[c / 11], c % 11) ||
                out_last !== ((c % 11) == 10)) begin
                n_fail++;
                $display("FAIL fill slice %0d: valid/idx/data/last actual=%b/%0d/%h/%b required=1/%0d/%h/%b",
                         c, out_valid, out_idx, out_data, out_last, c % 11,
                         slice_of(fr[c / 11], c % 11), ((c % 11) == 10));
            end
            if (in_valid && in_ready && acc < 0) begin
                acc = c;
            end
            tick();
            if (acc >= 0) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc !== 11 || frames_done !== 16'd6) begin
            n_fail++;
            $display("FAIL fill accept4/done: accept_cycle/frames_done actual=%0d/%0d required=11/6",
                     acc, frames_done);
        end
        stream_frame(fr[3], 1'b0, "fill_fourth");
        n_checks++;
        if (frames_done !== 16'd7) begin
            n_fail++;
            $display("FAIL fill final done: actual=%0d required=7", frames_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [95:0] f5;
        logic [95:0] f6;
        logic [95:0] f7;
        int t;
        f5 = mk(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98);
        f6 = mk(32'hFFFF0000, 32'h0000FFFF, 32'hAAAA5555);
        f7 = mk(32'h00000000, 32'h00000000, 32'h000001FF);
        out_ready = 1'b0;
        send_frame(f5);
        send_frame(f6);
        out_ready = 1'b1;
        t = 0;
        while (out_idx !== 4'd5 && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (out_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_mid reach idx5: actual=%0d required=5", out_idx);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid in_ready: actual=%b required=0", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || frames_done !== 16'd0 || out_idx !== 4'd0 || out_data !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_mid state: valid/done/idx/data actual=%b/%0d/%0d/%h required=0/0/0/000",
                     out_valid, frames_done, out_idx, out_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid stale %0d: out_valid actual=%b required=0", i, out_valid);
            end
        end
        send_frame(f7);
        wait_valid("reset_mid");
        stream_frame(f7, 1'b0, "reset_mid_new");
        n_checks++;
        if (frames_done !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid done: frames_done/out_valid actual=%0d/%b required=1/0",
                     frames_done, out_valid);
        end
    endtask

    task automatic test_wrap();
        force dut.r_frames_done = 16'hFFFF;
        #1;
        release dut.r_frames_done;
        #1;
        n_checks++;
        if (frames_done !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap preload: actual=%h required=ffff", frames_done);
        end
        out_ready = 1'b1;
        send_frame(mk(32'h1, 32'h2, 32'h3));
        wait_valid("wrap");
        stream_frame(mk(32'h1, 32'h2, 32'h3), 1'b0, "wrap");
        n_checks++;
        if (frames_done !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: actual=%h required=0000", frames_done);
        end
    endtask

`ifdef FRAME_SLICER_PARITY_EN
    task automatic test_parity_inj();
        out_ready = 1'b1;
        in_par_err_inj = 1'b1;
        send_frame(mk(32'h5, 32'h0, 32'h4));
        in_par_err_inj = 1'b0;
        wait_valid("parity_inj");
        stream_frame(mk(32'h5, 32'h0, 32'h4), 1'b1, "parity_inj");
        n_checks++;
        if (obs_par[0] !== 1'b0 || obs_par[7] !== 1'b0 || obs_par[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_inj hand: par0/par7/par1 actual=%b/%b/%b required=0/0/0",
                     obs_par[0], obs_par[7], obs_par[1]);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pattern();
        test_all_ones();
        test_backpressure();
        test_fill();
        test_reset_mid();
        test_wrap();
`ifdef FRAME_SLICER_PARITY_EN
        test_parity_inj();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
